sdram_arbiter: RTL and testbench

Slot-based request arbiter that sits directly upstream of the byte-wide SDRAM controller. It merges three clients onto the controller's single oe/we/addr/din port: ROM/file download (ioctl), ULA video fetch and Z80 CPU. It holds each granted access stable for one full clkref period (one SDRAM cycle) and returns read data to the winning client. It also guarantees that an idle slot, and therefore an auto-refresh, occurs at least every REFRESH_INTERVAL slots.

---
 rtl/sdram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Slot-based arbiter merging ROM download, ULA video and Z80 CPU onto one
// byte-wide SDRAM controller port; every access is held for a full clkref slot.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 96
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        clkref,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_overrun,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  typedef enum logic [1:0] {OWN_IDLE, OWN_DL, OWN_VID, OWN_CPU} owner_t;

  localparam logic [7:0] REF_LAST = 8'(REFRESH_INTERVAL - 1);

  logic        r_clkref_d;
  owner_t      r_owner;
  logic        r_cpu_wr;
  logic [7:0]  r_refresh_cnt;
  logic        r_dl_full;
  logic [24:0] r_dl_addr;
  logic [7:0]  r_dl_data;
  logic        r_dl_overrun;
  logic        r_vid_ack;
  logic        r_cpu_ack;
  logic [7:0]  r_vid_dout;
  logic [7:0]  r_cpu_dout;
  logic [24:0] r_mem_addr;
  logic [7:0]  r_mem_din;
  logic        r_mem_oe;
  logic        r_mem_we;

  logic   w_slot_start;
  logic   w_dl_drain;
  logic   w_dl_elig;
  logic   w_vid_elig;
  logic   w_cpu_elig;
  owner_t w_next;

  // A client just acked on this slot_start sits out the arbitration at that same edge.
  assign w_slot_start = clkref & ~r_clkref_d;
  assign w_dl_drain   = w_slot_start & (r_owner == OWN_DL);
  assign w_dl_elig    = r_dl_full & (r_owner != OWN_DL);
  assign w_vid_elig   = vid_req & (r_owner != OWN_VID);
  assign w_cpu_elig   = cpu_req & (r_owner != OWN_CPU);

  // Owner of the next slot: forced refresh first, then DL > VID > CPU with CPU behind VID.
  always_comb begin
    w_next = OWN_IDLE;
    if (r_refresh_cnt == REF_LAST) begin
      w_next = OWN_IDLE;
    end else if (w_dl_elig) begin
      w_next = OWN_DL;
    end else if (w_cpu_elig && (r_owner == OWN_VID)) begin
      w_next = OWN_CPU;
    end else if (w_vid_elig) begin
      w_next = OWN_VID;
    end else if (w_cpu_elig) begin
      w_next = OWN_CPU;
    end else begin
      w_next = OWN_IDLE;
    end
  end

  // One-entry download buffer; a strobe landing on the draining edge still fits.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_dl_full    <= 1'b0;
      r_dl_addr    <= 25'd0;
      r_dl_data    <= 8'd0;
      r_dl_overrun <= 1'b0;
    end else if (dl_wr && (!r_dl_full || w_dl_drain)) begin
      r_dl_full <= 1'b1;
      r_dl_addr <= dl_addr;
      r_dl_data <= dl_data;
    end else if (dl_wr) begin
      r_dl_overrun <= 1'b1;
    end else if (w_dl_drain) begin
      r_dl_full <= 1'b0;
    end
  end

  // Slot engine: complete the previous owner, grant the next and drive the controller.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_clkref_d    <= 1'b0;
      r_owner       <= OWN_IDLE;
      r_cpu_wr      <= 1'b0;
      r_refresh_cnt <= 8'd0;
      r_vid_ack     <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_vid_dout    <= 8'd0;
      r_cpu_dout    <= 8'd0;
      r_mem_addr    <= 25'd0;
      r_mem_din     <= 8'd0;
      r_mem_oe      <= 1'b0;
      r_mem_we      <= 1'b0;
    end else begin
      r_clkref_d <= clkref;
      r_vid_ack  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      if (w_slot_start) begin
        case (r_owner)
          OWN_VID: begin
            r_vid_dout <= mem_dout;
            r_vid_ack  <= 1'b1;
          end
          OWN_CPU: begin
            if (!r_cpu_wr) begin
              r_cpu_dout <= mem_dout;
            end
            r_cpu_ack <= 1'b1;
          end
          default: ;
        endcase
        r_owner  <= w_next;
        r_mem_oe <= 1'b0;
        r_mem_we <= 1'b0;
        case (w_next)
          OWN_DL: begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_dl_addr;
            r_mem_din  <= r_dl_data;
          end
          OWN_VID: begin
            r_mem_oe   <= 1'b1;
            r_mem_addr <= vid_addr;
          end
          OWN_CPU: begin
            r_cpu_wr   <= cpu_we;
            r_mem_oe   <= ~cpu_we;
            r_mem_we   <= cpu_we;
            r_mem_addr <= cpu_addr;
            if (cpu_we) begin
              r_mem_din <= cpu_din;
            end
          end
          default: ;
        endcase
        r_refresh_cnt <= (w_next == OWN_IDLE) ? 8'd0 : (r_refresh_cnt + 8'd1);
      end
    end
  end

  assign dl_overrun = r_dl_overrun;
  assign vid_ack    = r_vid_ack;
  assign vid_dout   = r_vid_dout;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_dout   = r_cpu_dout;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_oe     = r_mem_oe;
  assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios then random traffic, every clk
// compared against a slot-level reference model and a byte-wide SDRAM model.
module tb_sdram_arbiter;

  localparam int RI = 4;
  localparam int O_IDLE = 0;
  localparam int O_DL   = 1;
  localparam int O_VID  = 2;
  localparam int O_CPU  = 3;

  logic        clk;
  logic        init_n;
  logic        clkref;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_overrun;
  logic        vid_req;
  logic [24:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_dout;
  logic        cpu_req;
  logic        cpu_we;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_oe;
  logic        mem_we;
  logic [7:0]  mem_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_owner;
  logic        m_wr;
  int          m_cnt;
  logic        m_dl_full;
  logic [24:0] m_dl_addr;
  logic [7:0]  m_dl_data;
  logic        m_ovr;
  logic [7:0]  m_vdout;
  logic [7:0]  m_cdout;
  logic        m_oe;
  logic        m_we;
  logic [24:0] m_addr;
  logic [7:0]  m_din;
  logic        e_vack;
  logic        e_cack;
  logic [7:0]  ref_mem [logic [24:0]];

  // SDRAM environment model (addresses in use have distinct low bytes)
  logic [7:0]  env_mem [256];
  bit          env_vld [256];

  sdram_arbiter #(.REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .init_n(init_n), .clkref(clkref),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_overrun(dl_overrun),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] preload(input logic [24:0] a);
    return (a == 25'h0012345) ? 8'hA5 : 8'h00;
  endfunction

  function automatic logic [7:0] env_rd(input logic [24:0] a);
    return env_vld[a[7:0]] ? env_mem[a[7:0]] : preload(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [24:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : preload(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr[7:0]] <= mem_din;
      env_vld[mem_addr[7:0]] <= 1'b1;
    end
    mem_dout <= mem_oe ? env_rd(mem_addr) : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = O_IDLE; m_wr = 1'b0; m_cnt = 0;
    m_dl_full = 1'b0; m_dl_addr = 25'd0; m_dl_data = 8'd0; m_ovr = 1'b0;
    m_vdout = 8'd0; m_cdout = 8'd0;
    m_oe = 1'b0; m_we = 1'b0; m_addr = 25'd0; m_din = 8'd0;
    e_vack = 1'b0; e_cack = 1'b0;
  endtask

  // One slot boundary: finish the old owner, pick the new one by the published rules.
  task automatic model_slot_start();
    int   nxt;
    logic dl_el, v_el, c_el;
    e_vack = (m_owner == O_VID);
    e_cack = (m_owner == O_CPU);
    if (m_owner == O_VID) m_vdout = ref_rd(m_addr);
    if (m_owner == O_CPU && !m_wr) m_cdout = ref_rd(m_addr);
    dl_el = m_dl_full && (m_owner != O_DL);
    if (m_owner == O_DL) m_dl_full = 1'b0;
    v_el = vid_req && (m_owner != O_VID);
    c_el = cpu_req && (m_owner != O_CPU);
    if (m_cnt == RI - 1)                nxt = O_IDLE;
    else if (dl_el)                     nxt = O_DL;
    else if (c_el && m_owner == O_VID)  nxt = O_CPU;
    else if (v_el)                      nxt = O_VID;
    else if (c_el)                      nxt = O_CPU;
    else                                nxt = O_IDLE;
    m_oe = 1'b0;
    m_we = 1'b0;
    case (nxt)
      O_DL: begin
        m_we = 1'b1; m_addr = m_dl_addr; m_din = m_dl_data; ref_mem[m_addr] = m_din;
      end
      O_VID: begin
        m_oe = 1'b1; m_addr = vid_addr;
      end
      O_CPU: begin
        m_wr = cpu_we; m_addr = cpu_addr;
        if (cpu_we) begin
          m_we = 1'b1; m_din = cpu_din; ref_mem[m_addr] = m_din;
        end else begin
          m_oe = 1'b1;
        end
      end
      default: ;
    endcase
    m_cnt   = (nxt == O_IDLE) ? 0 : m_cnt + 1;
    m_owner = nxt;
  endtask

  task automatic check_outs(input int k);
    logic first;
    first = (k == 0);
    chk("vid_ack",    32'(vid_ack),    32'(e_vack & first));
    chk("cpu_ack",    32'(cpu_ack),    32'(e_cack & first));
    chk("vid_dout",   32'(vid_dout),   32'(m_vdout));
    chk("cpu_dout",   32'(cpu_dout),   32'(m_cdout));
    chk("mem_oe",     32'(mem_oe),     32'(m_oe));
    chk("mem_we",     32'(mem_we),     32'(m_we));
    chk("mem_addr",   32'(mem_addr),   32'(m_addr));
    chk("mem_din",    32'(mem_din),    32'(m_din));
    chk("dl_overrun", 32'(dl_overrun), 32'(m_ovr));
    chk("oe_we_excl", 32'(mem_oe & mem_we), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_oe"},   32'(mem_oe),     32'd0);
    chk({tag, "_we"},   32'(mem_we),     32'd0);
    chk({tag, "_addr"}, 32'(mem_addr),   32'd0);
    chk({tag, "_din"},  32'(mem_din),    32'd0);
    chk({tag, "_vack"}, 32'(vid_ack),    32'd0);
    chk({tag, "_cack"}, 32'(cpu_ack),    32'd0);
    chk({tag, "_vdo"},  32'(vid_dout),   32'd0);
    chk({tag, "_cdo"},  32'(cpu_dout),   32'd0);
    chk({tag, "_ovr"},  32'(dl_overrun), 32'd0);
  endtask

  // One 8-clk slot; clkref rises so cycle 0's edge is the slot_start.
  task automatic slot(input int wr_at, input int wr2_at, input int rst_at);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      clkref = (k < 4);
      dl_wr  = (k == wr_at) || (k == wr2_at);
      if (rst_at >= 0 && k == 5) init_n = 1'b1;
      @(posedge clk);
      #1;
      if (k == 0) model_slot_start();
      if (dl_wr) begin
        if (!m_dl_full) begin
          m_dl_full = 1'b1; m_dl_addr = dl_addr; m_dl_data = dl_data;
        end else begin
          m_ovr = 1'b1;
        end
      end
      check_outs(k);
      if (k == rst_at) begin
        #1 init_n = 1'b0;
        #1 check_reset_vals("rst_mid");
        model_reset();
      end
    end
  endtask

  logic [7:0] dl_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    init_n = 1'b0; clkref = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 8'd0;
    vid_req = 1'b0; vid_addr = 25'd0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 25'd0; cpu_din = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    init_n = 1'b1;
    @(posedge clk);
    #1;

    // CPU read with request held across its ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0012345;
    slot(-1, -1, -1);
    slot(-1, -1, -1);
    chk("cpu_rd_data", 32'(cpu_dout), 32'h000000A5);
    slot(-1, -1, -1);
    cpu_req = 1'b0;
    slot(-1, -1, -1);
    slot(-1, -1, -1);

    // VID/CPU contention (also exercises forced refresh slots)
    vid_req = 1'b1; vid_addr = 25'h0000120;
    cpu_req = 1'b1; cpu_addr = 25'h0012345;
    repeat (10) slot(-1, -1, -1);
    cpu_req = 1'b0;
    repeat (6) slot(-1, -1, -1);
    vid_req = 1'b0;
    slot(-1, -1, -1);

    // Lossless download while the CPU is requesting
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000010;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 12 && m_dl_full && m_owner != O_DL; g++) slot(-1, -1, -1);
      dl_addr = 25'(i);
      dl_data = dl_vals[i];
      slot((m_dl_full && m_owner == O_DL) ? 0 : 1, -1, -1);
    end
    repeat (4) slot(-1, -1, -1);
    cpu_req = 1'b0;
    repeat (2) slot(-1, -1, -1);
    for (int i = 0; i < 4; i++) chk("dl_mem", 32'(env_rd(25'(i))), 32'(dl_vals[i]));
    chk("dl_no_ovr", 32'(dl_overrun), 32'd0);

    // Two strobes 2 clk apart inside one slot overrun the buffer
    dl_addr = 25'h0000006; dl_data = 8'h66;
    slot(2, 4, -1);
    chk("ovr_set", 32'(dl_overrun), 32'd1);
    repeat (3) slot(-1, -1, -1);
    chk("ovr_sticky", 32'(dl_overrun), 32'd1);

    // CPU write at the top address
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h1FFFFFF; cpu_din = 8'h5A;
    for (int g = 0; g < 6 && m_owner != O_CPU; g++) slot(-1, -1, -1);
    cpu_req = 1'b0;
    slot(-1, -1, -1);
    chk("cpu_wr_mem", 32'(env_rd(25'h1FFFFFF)), 32'h0000005A);
    slot(-1, -1, -1);

    // Reset in the middle of a CPU write slot, then normal grant after release
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h0000230; cpu_din = 8'h77;
    for (int g = 0; g < 6 && m_owner != O_CPU; g++) slot(-1, -1, -1);
    slot(-1, -1, 2);
    slot(-1, -1, -1);
    chk("post_rst_grant_we", 32'(mem_we), 32'd1);
    cpu_req = 1'b0;
    repeat (2) slot(-1, -1, -1);

    // Random traffic; inputs only change when the client is idle or being acked
    for (int s = 0; s < 300; s++) begin
      int w1, w2;
      if (!vid_req || m_owner == O_VID) begin
        vid_req  = 1'($urandom_range(0, 1));
        vid_addr = 25'($urandom_range(0, 7));
      end
      if (!cpu_req || m_owner == O_CPU) begin
        cpu_req  = 1'($urandom_range(0, 1));
        cpu_we   = 1'($urandom_range(0, 1));
        cpu_addr = 25'($urandom_range(0, 7));
        cpu_din  = 8'($urandom_range(0, 255));
      end
      dl_addr = 25'($urandom_range(0, 7));
      dl_data = 8'($urandom_range(0, 255));
      w1 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      w2 = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      slot(w1, w2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
